// File: rtl/addsub_seq_acc_pkg.sv
// Shared types and helpers for the sliced add/subtract accumulator.
package addsub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest datapath the saturation helper can describe.
    localparam int unsigned SAT_MAXW = 64;

    // Clamp value for an n-bit signed result: most negative if neg, else most positive.
    function automatic logic [SAT_MAXW-1:0] sat_const(input int unsigned n, input logic neg);
        logic [SAT_MAXW-1:0] r;
        r = {{(SAT_MAXW-1){1'b0}}, 1'b1} << (n - 1);
        if (!neg) r = r - 1'b1;
        return r;
    endfunction

    // Signed overflow: both operands share a sign that the sum does not.
    function automatic logic ovf_detect(input logic g_msb, input logic h_msb, input logic m_msb);
        return (g_msb & h_msb & ~m_msb) | (~g_msb & ~h_msb & m_msb);
    endfunction

endpackage

// File: rtl/addsub_seq_acc_slice_adder.sv
// K-bit ripple slice, reused every cycle for successive operand slices.
module addsub_slice_adder #(
    parameter int K = 4
) (
    input  logic [K-1:0] a_i,
    input  logic [K-1:0] b_i,
    input  logic         c_i,
    output logic [K-1:0] s_o,
    output logic         c_o
);

    // Sum with carry kept as the extra top bit.
    always_comb begin
        {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{K{1'b0}}, c_i};
    end

endmodule

// File: rtl/addsub_seq_acc.sv
// N-bit add/subtract with accumulator, computed K bits per cycle.
module addsub_seq_acc
    import addsub_seq_pkg::*;
#(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         InValid,
    output logic         InReady,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         AddSub,
    input  logic         Sel,
    input  logic         Sat,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [N-1:0] Z,
    output logic         Overflow,
    output logic         Carryout,
    output logic         StickyOvf,
    input  logic         ClrSticky
);

    localparam int NS = N / K;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    state_e         state_q, state_d;
    logic [N-1:0]   g_q, g_d, h_q, h_d, m_q, m_d, z_q, z_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d, sat_q, sat_d;
    logic           ovf_q, ovf_d, cout_q, cout_d, sticky_q, sticky_d;

    logic [31:0]    lsb;
    logic [K-1:0]   sl_a, sl_b, sl_s;
    logic           sl_co;
    logic [N-1:0]   m_next, sat_val;
    logic           last, ovf_c, commit;

    // Select the current operand slices and merge the new sum slice into the result.
    always_comb begin
        lsb     = 32'(idx_q) * 32'(K);
        sl_a    = K'(g_q >> lsb);
        sl_b    = K'(h_q >> lsb);
        m_next  = (m_q & ~(N'({K{1'b1}}) << lsb)) | (N'(sl_s) << lsb);
        last    = (state_q == BUSY) && (idx_q == IW'(NS - 1));
        ovf_c   = ovf_detect(g_q[N-1], h_q[N-1], m_next[N-1]);
        sat_val = N'(sat_const(N, g_q[N-1]));
        commit  = last;
    end

    addsub_slice_adder #(.K(K)) u_slice (
        .a_i (sl_a),
        .b_i (sl_b),
        .c_i (carry_q),
        .s_o (sl_s),
        .c_o (sl_co)
    );

    // Next state for FSM, capture registers and committed flags.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        h_d     = h_q;
        m_d     = m_q;
        z_d     = z_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sat_d   = sat_q;
        ovf_d   = ovf_q;
        cout_d  = cout_q;
        // A committing overflow beats a same-cycle clear.
        sticky_d = (ClrSticky ? 1'b0 : sticky_q) | (commit & ovf_c);
        unique case (state_q)
            IDLE: begin
                if (InValid) begin
                    g_d     = Sel ? z_q : A;
                    h_d     = AddSub ? ~B : B;
                    carry_d = AddSub;
                    sat_d   = Sat;
                    idx_d   = '0;
                    m_d     = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                m_d     = m_next;
                carry_d = sl_co;
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    idx_d   = '0;
                    ovf_d   = ovf_c;
                    cout_d  = sl_co;
                    z_d     = (sat_q && ovf_c) ? sat_val : m_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OutReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any work in flight.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            g_q      <= '0;
            h_q      <= '0;
            m_q      <= '0;
            z_q      <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sat_q    <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            h_q      <= h_d;
            m_q      <= m_d;
            z_q      <= z_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            sat_q    <= sat_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
            sticky_q <= sticky_d;
        end
    end

    assign InReady   = (state_q == IDLE);
    assign OutValid  = (state_q == DONE);
    assign Z         = z_q;
    assign Overflow  = ovf_q;
    assign Carryout  = cout_q;
    assign StickyOvf = sticky_q;

endmodule

// File: tb/tb_addsub_seq_acc.sv
// Directed bench for addsub_seq_acc at N=16, K=4.
module tb_addsub_seq_acc;

    localparam int N = 16;
    localparam int K = 4;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         InValid, InReady, AddSub, Sel, Sat;
    logic         OutValid, OutReady, Overflow, Carryout, StickyOvf, ClrSticky;
    logic [N-1:0] A, B, Z;

    int checks   = 0;
    int failures = 0;

    addsub_seq_acc #(.N(N), .K(K)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .InValid   (InValid),
        .InReady   (InReady),
        .A         (A),
        .B         (B),
        .AddSub    (AddSub),
        .Sel       (Sel),
        .Sat       (Sat),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .Z         (Z),
        .Overflow  (Overflow),
        .Carryout  (Carryout),
        .StickyOvf (StickyOvf),
        .ClrSticky (ClrSticky)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request and let it be accepted on the next rising edge.
    task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic sub, input logic sel, input logic sat);
        @(negedge Clock);
        A = a; B = b; AddSub = sub; Sel = sel; Sat = sat; InValid = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0;
        check("accepted_inready_low", 32'(InReady), 32'd0);
    endtask

    // Count edges until OutValid, bounded; expect N/K.
    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!OutValid && n < 20) begin
            @(posedge Clock); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(N / K));
    endtask

    task automatic handshake(input string tag);
        @(negedge Clock);
        OutReady = 1'b1;
        @(posedge Clock); #1;
        check({tag, "_outvalid_drop"}, 32'(OutValid), 32'd0);
        check({tag, "_inready_rise"}, 32'(InReady), 32'd1);
        OutReady = 1'b0;
    endtask

    task automatic op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic sub, input logic sel, input logic sat,
                      input logic [N-1:0] ez, input logic eo, input logic ec);
        accept(a, b, sub, sel, sat);
        wait_out(tag);
        check({tag, "_Z"}, 32'(Z), 32'(ez));
        check({tag, "_ovf"}, 32'(Overflow), 32'(eo));
        check({tag, "_cout"}, 32'(Carryout), 32'(ec));
        handshake(tag);
    endtask

    initial begin
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0; ClrSticky = 1'b0;
        A = '0; B = '0; AddSub = 1'b0; Sel = 1'b0; Sat = 1'b0;
        #1;
        check("rst_inready", 32'(InReady), 32'd1);
        repeat (2) @(posedge Clock);
        #1;
        check("rst_outvalid", 32'(OutValid), 32'd0);
        check("rst_Z", 32'(Z), 32'd0);
        check("rst_flags", {29'd0, Overflow, Carryout, StickyOvf}, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;

        // Plain add and both subtract directions.
        op("add1", 16'h1234, 16'h0111, 1'b0, 1'b0, 1'b0, 16'h1345, 1'b0, 1'b0);
        op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        op("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b1);
        check("sticky_clean", 32'(StickyOvf), 32'd0);

        // Signed overflow, wrapped and saturated.
        op("ovf_wrap", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0);
        check("sticky_set", 32'(StickyOvf), 32'd1);
        op("ovf_satp", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0);
        op("ovf_satn", 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);

        // Accumulate through Z; A is junk and must be ignored.
        op("acc_seed", 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);
        op("acc1", 16'hFFFF, 16'h0010, 1'b0, 1'b1, 1'b0, 16'h0020, 1'b0, 1'b0);
        op("acc2", 16'hABCD, 16'h0010, 1'b0, 1'b1, 1'b0, 16'h0030, 1'b0, 1'b0);
        op("acc3", 16'h5555, 16'h0010, 1'b0, 1'b1, 1'b0, 16'h0040, 1'b0, 1'b0);
        check("sticky_held", 32'(StickyOvf), 32'd1);
        @(negedge Clock);
        ClrSticky = 1'b1;
        @(posedge Clock); #1;
        ClrSticky = 1'b0;
        check("sticky_clr", 32'(StickyOvf), 32'd0);

        // Backpressure in DONE with a competing request on the input.
        accept(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
        wait_out("bp");
        @(negedge Clock);
        A = 16'h1111; B = 16'h1111; Sel = 1'b0; AddSub = 1'b0; InValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clock); #1;
            check("bp_stable", {13'd0, OutValid, InReady, Overflow, Z},
                  {13'd0, 1'b1, 1'b0, 1'b0, 16'h0003});
        end
        @(negedge Clock);
        InValid = 1'b0;
        handshake("bp");
        check("bp_Z_kept", 32'(Z), 32'h0003);

        // Reset in the middle of BUSY.
        accept(16'h1000, 16'h0100, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        check("abort_Z", 32'(Z), 32'd0);
        check("abort_outvalid", 32'(OutValid), 32'd0);
        check("abort_inready", 32'(InReady), 32'd1);
        check("abort_flags", {29'd0, Overflow, Carryout, StickyOvf}, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        op("post_rst", 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
